// File: rtl/osc_freq_monitor.sv
// Multi-channel oscillator frequency monitor: counts synchronised rising edges per channel over a
// fixed CLK window and checks the counts against per-channel limits. Optional IRQ via OSC_MON_IRQ_EN.
module osc_freq_monitor #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 50000
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic                      ENABLE,
  input  logic [NUM_CH-1:0]         OSC_IN,
  input  logic [NUM_CH*CNT_W-1:0]   MIN_CNT,
  input  logic [NUM_CH*CNT_W-1:0]   MAX_CNT,
  input  logic [NUM_CH-1:0]         CLR_FAULT,
  output logic [NUM_CH*CNT_W-1:0]   CNT_OUT,
  output logic                      CNT_VALID,
  output logic [NUM_CH-1:0]         IN_RANGE,
  output logic [NUM_CH-1:0]         FAULT
`ifdef OSC_MON_IRQ_EN
  ,
  output logic                      IRQ
`endif
);

  localparam int WIN_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  state_t              state;
  logic [1:0]          arm_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic                res_pend;

  logic [NUM_CH-1:0]   sync1, sync2, sync3;
  logic [NUM_CH-1:0]   edge_det;
  logic [NUM_CH-1:0]   in_rng_c;

  logic [CNT_W-1:0]    edge_cnt [NUM_CH];
  logic [CNT_W-1:0]    cnt_inc  [NUM_CH];
  logic [CNT_W-1:0]    fin_cnt  [NUM_CH];

  logic                win_last;

  assign edge_det = sync2 & ~sync3;
  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));

  // Saturating next count, including an edge seen in the current cycle
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_inc[i] = edge_cnt[i];
      if (edge_det[i] && (edge_cnt[i] != '1))
        cnt_inc[i] = edge_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    in_rng_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      in_rng_c[i] = (MIN_CNT[i*CNT_W +: CNT_W] <= fin_cnt[i]) &&
                    (fin_cnt[i] <= MAX_CNT[i*CNT_W +: CNT_W]);
  end

  // The result of a window is published one cycle after its terminal cycle, overlapping the
  // first cycle of the next window, so back-to-back windows need no gap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_IDLE;
      arm_cnt   <= '0;
      win_cnt   <= '0;
      res_pend  <= 1'b0;
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      CNT_OUT   <= '0;
      CNT_VALID <= 1'b0;
      IN_RANGE  <= '0;
      FAULT     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        edge_cnt[i] <= '0;
        fin_cnt[i]  <= '0;
      end
    end else begin
      sync1     <= OSC_IN;
      sync2     <= sync1;
      sync3     <= sync2;
      res_pend  <= 1'b0;
      CNT_VALID <= 1'b0;

      if (res_pend) begin
        CNT_VALID <= 1'b1;
        IN_RANGE  <= in_rng_c;
        FAULT     <= (FAULT & ~CLR_FAULT) | ~in_rng_c;
        for (int unsigned i = 0; i < NUM_CH; i++)
          CNT_OUT[i*CNT_W +: CNT_W] <= fin_cnt[i];
      end else begin
        FAULT <= FAULT & ~CLR_FAULT;
      end

      case (state)
        ST_IDLE: begin
          win_cnt <= '0;
          arm_cnt <= '0;
          for (int unsigned i = 0; i < NUM_CH; i++)
            edge_cnt[i] <= '0;
          if (ENABLE)
            state <= ST_ARM;
        end

        ST_ARM: begin
          for (int unsigned i = 0; i < NUM_CH; i++)
            edge_cnt[i] <= '0;
          if (!ENABLE) begin
            state <= ST_IDLE;
          end else if (arm_cnt == 2'd2) begin
            state   <= ST_MEASURE;
            win_cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end

        ST_MEASURE: begin
          if (!ENABLE) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++)
              edge_cnt[i] <= '0;
          end else if (win_last) begin
            win_cnt  <= '0;
            res_pend <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              fin_cnt[i]  <= cnt_inc[i];
              edge_cnt[i] <= '0;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++)
              edge_cnt[i] <= cnt_inc[i];
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OSC_MON_IRQ_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      IRQ <= 1'b0;
    else
      IRQ <= |FAULT;
  end
`endif

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Self-checking bench for osc_freq_monitor: directed steps with randomized oscillator waves and
// limits, checked against a cycle-history edge-count model.
module tb_osc_freq_monitor;

  localparam int W    = 1000;
  localparam int HMAX = 16384;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        ENABLE;
  logic [1:0]  OSC_IN;
  logic [31:0] MIN_CNT, MAX_CNT;
  logic [1:0]  CLR_FAULT;
  logic [31:0] CNT_OUT;
  logic        CNT_VALID;
  logic [1:0]  IN_RANGE, FAULT;

  logic        en_s;
  logic [0:0]  osc_s, clr_s, inr_s, fault_s;
  logic [3:0]  min_s, max_s, cnt_s;
  logic        valid_s;
`ifdef OSC_MON_IRQ_EN
  logic        IRQ, irq_s;
`endif

  osc_freq_monitor #(.NUM_CH(2), .CNT_W(16), .WINDOW(W)) dut (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .OSC_IN(OSC_IN),
    .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT), .CLR_FAULT(CLR_FAULT),
    .CNT_OUT(CNT_OUT), .CNT_VALID(CNT_VALID), .IN_RANGE(IN_RANGE), .FAULT(FAULT)
`ifdef OSC_MON_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  osc_freq_monitor #(.NUM_CH(1), .CNT_W(4), .WINDOW(W)) dut_s (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(en_s), .OSC_IN(osc_s),
    .MIN_CNT(min_s), .MAX_CNT(max_s), .CLR_FAULT(clr_s),
    .CNT_OUT(cnt_s), .CNT_VALID(valid_s), .IN_RANGE(inr_s), .FAULT(fault_s)
`ifdef OSC_MON_IRQ_EN
    , .IRQ(irq_s)
`endif
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int per[3], ph[3];
  bit lvl[3];
  bit hist[3][HMAX];
  int lmin[2], lmax[2], exp_cnt[2];
  bit exp_inr[2], fault_m[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge; hist[ch][c] is the wave in cycle c
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, HMAX);
      $fatal(1, "cycle budget exhausted");
    end
    for (int ch = 0; ch < 3; ch++) begin
      bit v;
      if (per[ch] == 0) v = lvl[ch];
      else              v = ((cyc + ph[ch]) % per[ch]) < (per[ch] / 2);
      hist[ch][cyc] = v;
    end
    OSC_IN = {hist[1][cyc], hist[0][cyc]};
    osc_s  = hist[2][cyc];
  endtask

  // A rise of the raw wave between cycles k-3 and k-2 is seen by the 2-FF synchroniser in cycle k
  function automatic int model_cnt(input int ch, input int start, input int len, input int maxv);
    int c = 0;
    for (int k = start; k < start + len; k++)
      if (k >= 3 && k < HMAX && hist[ch][k-2] && !hist[ch][k-3]) c++;
    return (c > maxv) ? maxv : c;
  endfunction

  task automatic set_lim(input int ch, input int mn, input int mx);
    lmin[ch] = mn;
    lmax[ch] = mx;
    MIN_CNT[ch*16 +: 16] = 16'(mn);
    MAX_CNT[ch*16 +: 16] = 16'(mx);
  endtask

  task automatic rand_lim(input int ch);
    int nom, mn, mx, t;
    nom = W / per[ch];
    mn  = nom - int'($urandom_range(0, 2));
    mx  = nom + int'($urandom_range(0, 2));
    if ($urandom_range(0, 3) == 0) begin
      t = mn; mn = mx; mx = t;
    end
    set_lim(ch, mn, mx);
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (CNT_VALID === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Result visible in cycle v covers window cycles [v-W-1, v-2]
  task automatic check_result(input string tag, input int v, input logic [1:0] clr);
    for (int ch = 0; ch < 2; ch++) begin
      exp_cnt[ch] = model_cnt(ch, v - W - 1, W, 65535);
      exp_inr[ch] = (lmin[ch] <= exp_cnt[ch]) && (exp_cnt[ch] <= lmax[ch]);
      fault_m[ch] = (fault_m[ch] & !clr[ch]) | !exp_inr[ch];
      chk($sformatf("%s_cnt%0d", tag, ch), CNT_OUT[ch*16 +: 16], exp_cnt[ch]);
      chk($sformatf("%s_inr%0d", tag, ch), IN_RANGE[ch], exp_inr[ch]);
      chk($sformatf("%s_fault%0d", tag, ch), FAULT[ch], fault_m[ch]);
    end
  endtask

  initial begin
    int e, v, vp, nval;
    logic nz;

    // 1: reset with random inputs, then idle release
    RESETN = 1'b0;
    ENABLE = 1'($urandom_range(0, 1));
    en_s   = 1'($urandom_range(0, 1));
    MIN_CNT = $urandom; MAX_CNT = $urandom; CLR_FAULT = 2'($urandom);
    min_s = 4'($urandom); max_s = 4'($urandom); clr_s = 1'($urandom);
    for (int ch = 0; ch < 3; ch++) begin
      per[ch] = $urandom_range(4, 80);
      ph[ch]  = $urandom_range(0, 99);
      lvl[ch] = 1'b0;
    end
    OSC_IN = 2'($urandom); osc_s = 1'($urandom);
    #1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_cnt_out", CNT_OUT, 0);
    chk("rst_valid", CNT_VALID, 0);
    chk("rst_in_range", IN_RANGE, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_small", {cnt_s, valid_s, inr_s, fault_s}, 0);
`ifdef OSC_MON_IRQ_EN
    chk("rst_irq", {IRQ, irq_s}, 0);
`endif
    ENABLE = 1'b0; en_s = 1'b0; CLR_FAULT = '0; clr_s = '0;
    RESETN = 1'b1;
    nz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      nz |= (|{CNT_OUT, CNT_VALID, IN_RANGE, FAULT, cnt_s, valid_s, inr_s, fault_s});
    end
    chk("idle_outputs_zero", nz, 0);

    // 2 + 4: nominal window, random ch1; narrow-counter instance saturates
    per[0] = 40;                    ph[0] = $urandom_range(0, 39);
    per[1] = $urandom_range(4, 80); ph[1] = $urandom_range(0, 99);
    per[2] = 4;                     ph[2] = $urandom_range(0, 3);
    set_lim(0, 24, 26);
    rand_lim(1);
    min_s = 4'd0; max_s = 4'd15;
    tick();
    ENABLE = 1'b1; en_s = 1'b1;
    e = cyc;
    wait_valid(1100, v);
    chk("first_valid_cycle", v, e + 1005);
    chk("ch0_period40_count", CNT_OUT[15:0], 25);
    check_result("w1", v, 2'b00);
    chk("sat_cnt", cnt_s, model_cnt(2, v - W - 1, W, 15));
    chk("sat_cnt_15", cnt_s, 15);
    chk("sat_valid", valid_s, 1);
    chk("sat_inr", inr_s, 1);
    en_s = 1'b0;
    tick();
    chk("valid_one_cycle", CNT_VALID, 0);
    vp = v;
    wait_valid(1100, v);
    chk("second_valid_cycle", v, vp + 1000);
    check_result("w2", v, 2'b00);

    // 3: ch1 stuck low -> fault, stays sticky until cleared
    per[1] = 0; lvl[1] = 1'b0;
    set_lim(1, 1, 100);
    vp = v;
    wait_valid(1100, v);
    chk("w3_cycle", v, vp + 1000);
    check_result("w3", v, 2'b00);
    wait_valid(1100, v);
    chk("stuck_cnt1", CNT_OUT[31:16], 0);
    check_result("w4", v, 2'b00);
    chk("stuck_fault1", FAULT[1], 1);
    tick();
`ifdef OSC_MON_IRQ_EN
    chk("irq_rise", IRQ, 1);
`endif
    per[1] = 40; ph[1] = $urandom_range(0, 39);
    set_lim(1, 20, 30);
    wait_valid(1100, v);
    check_result("w5", v, 2'b00);
    wait_valid(1100, v);
    check_result("w6", v, 2'b00);
    chk("sticky_fault1", FAULT[1], 1);
    chk("recovered_inr1", IN_RANGE[1], 1);
    CLR_FAULT = 2'b10;
    tick();
    CLR_FAULT = 2'b00;
    fault_m[1] = 1'b0;
    chk("clr_fault1", FAULT[1], 0);
    tick();
`ifdef OSC_MON_IRQ_EN
    chk("irq_fall", IRQ, fault_m[0] | fault_m[1]);
`endif

    // 5: drop ENABLE mid-window, outputs hold, re-enable gives a full window
    while (cyc < v + 500) tick();
    ENABLE = 1'b0;
    nval = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (CNT_VALID === 1'b1) nval++;
    end
    chk("abort_no_valid", nval, 0);
    chk("abort_hold_cnt", CNT_OUT, {16'(exp_cnt[1]), 16'(exp_cnt[0])});
    chk("abort_hold_inr", IN_RANGE, {exp_inr[1], exp_inr[0]});
    chk("abort_hold_fault", FAULT, {fault_m[1], fault_m[0]});
    ENABLE = 1'b1;
    e = cyc;
    wait_valid(1100, v);
    chk("reenable_valid_cycle", v, e + 1005);
    chk("reenable_full_cnt0", CNT_OUT[15:0], 25);
    check_result("w7", v, 2'b00);

    // 6: clear in the same cycle as an out-of-range result -> set wins
    set_lim(0, 30, 40);
    vp = v;
    while (cyc < vp + 999) tick();
    CLR_FAULT = 2'b01;
    tick();
    CLR_FAULT = 2'b00;
    chk("setclr_valid", CNT_VALID, 1);
    check_result("w8", cyc, 2'b01);
    chk("setclr_fault0", FAULT[0], 1);
    v = cyc;

    // Randomized back-to-back windows
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < 2; ch++) begin
        per[ch] = $urandom_range(4, 80);
        ph[ch]  = $urandom_range(0, 99);
        rand_lim(ch);
      end
      vp = v;
      wait_valid(1100, v);
      chk($sformatf("rnd%0d_cycle", r), v, vp + 1000);
      check_result($sformatf("rnd%0d", r), v, 2'b00);
    end

    // Reset mid-window clears everything immediately
    for (int i = 0; i < 300; i++) tick();
    RESETN = 1'b0;
    #1;
    chk("midrst_outputs", {CNT_OUT, CNT_VALID, IN_RANGE, FAULT}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
